// File: rtl/trig_phase_nco_if.sv
// Bus between the phase sequencer, its trig stage and the sample consumer.
// Quadrature signals exist only when TRIG_NCO_QUAD_EN is defined.
//
// Handshake: the master raises sample_valid with sample_out (and sample_q_out)
// stable and holds both unchanged until a cycle where sample_valid && sample_ready;
// that cycle completes the transfer. sample_ready may toggle freely and never
// depends combinationally on sample_valid.
interface trig_phase_nco_if #(
  parameter int WS = 10
);
  logic [31:0]   phase_out;
  logic [WS-1:0] mag_in;
  logic          sig_in;
  logic [WS:0]   sample_out;
  logic          sample_valid;
  logic          sample_ready;
`ifdef TRIG_NCO_QUAD_EN
  logic [31:0]   phase_q_out;
  logic [WS-1:0] mag_q_in;
  logic          sig_q_in;
  logic [WS:0]   sample_q_out;

  modport master (
    output phase_out, sample_out, sample_valid, phase_q_out, sample_q_out,
    input  mag_in, sig_in, sample_ready, mag_q_in, sig_q_in
  );
  modport slave (
    input  phase_out, sample_out, sample_valid, phase_q_out, sample_q_out,
    output mag_in, sig_in, sample_ready, mag_q_in, sig_q_in
  );
`else
  modport master (
    output phase_out, sample_out, sample_valid,
    input  mag_in, sig_in, sample_ready
  );
  modport slave (
    input  phase_out, sample_out, sample_valid,
    output mag_in, sig_in, sample_ready
  );
`endif
endinterface

// File: rtl/trig_phase_nco.sv
// Phase-accumulator sequencer for a combinational sine stage: present phase, let it settle,
// capture signed sample, advance phase modulo 2*PER. Optional quadrature path: TRIG_NCO_QUAD_EN.
module trig_phase_nco #(
  parameter int PER    = 3142,
  parameter int WS     = 10,
  parameter int SETTLE = 2    // 1..15 settle cycles before capture
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [31:0]       step,
  input  logic              step_load,
  trig_phase_nco_if.master  bus,
  output logic              overrun,
  output logic [1:0]        state_dbg
);

  localparam logic [32:0] PERIOD   = 33'(2 * PER);
  localparam logic [32:0] QOFF     = 33'(PER / 2);
  localparam logic [31:0] STEP_MAX = 32'(2 * PER - 1);
  localparam logic [3:0]  CNT_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t       state, state_nxt;
  logic [3:0]   cnt, cnt_nxt;
  logic         capture;
  logic         advance;

  logic [31:0]  acc;
  logic [31:0]  step_r;
  logic [32:0]  acc_sum;
  logic [31:0]  acc_next;
  logic [31:0]  step_clamped;

  logic [WS:0]  mag_ext;
  logic [WS:0]  sample_r;
  logic         valid_r;

  // acc and step_r are both below 2*PER, so one conditional subtract wraps the sum.
  assign acc_sum      = {1'b0, acc} + {1'b0, step_r};
  assign acc_next     = (acc_sum >= PERIOD) ? 32'(acc_sum - PERIOD) : acc_sum[31:0];
  assign step_clamped = ({1'b0, step} >= PERIOD) ? STEP_MAX : step;
  assign mag_ext      = {1'b0, bus.mag_in};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    advance   = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = 4'd0;
        end
      end
      S_SETTLE: begin
        if (cnt == CNT_LAST) state_nxt = S_CAPTURE;
        else                 cnt_nxt   = cnt + 4'd1;
      end
      S_CAPTURE: begin
        capture   = 1'b1;
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (valid_r && bus.sample_ready) begin
          advance   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A step load only changes step_r; acc moves solely on a completed handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= 32'd0;
      step_r <= 32'd0;
    end else begin
      if (step_load) step_r <= step_clamped;
      if (advance)   acc    <= acc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_r <= '0;
      valid_r  <= 1'b0;
    end else if (capture) begin
      sample_r <= bus.sig_in ? -mag_ext : mag_ext;
      valid_r  <= 1'b1;
    end else if (advance) begin
      valid_r  <= 1'b0;
    end
  end

  // Any tick outside IDLE is lost, including one coinciding with the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     overrun <= 1'b0;
    else if (en && state != S_IDLE) overrun <= 1'b1;
  end

  assign bus.phase_out    = acc;
  assign bus.sample_out   = sample_r;
  assign bus.sample_valid = valid_r;
  assign state_dbg        = state;

`ifdef TRIG_NCO_QUAD_EN
  logic [32:0] q_sum;
  logic [WS:0] mag_q_ext;
  logic [WS:0] sample_q_r;

  assign q_sum     = {1'b0, acc} + QOFF;
  assign mag_q_ext = {1'b0, bus.mag_q_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sample_q_r <= '0;
    else if (capture) sample_q_r <= bus.sig_q_in ? -mag_q_ext : mag_q_ext;
  end

  assign bus.phase_q_out  = (q_sum >= PERIOD) ? 32'(q_sum - PERIOD) : q_sum[31:0];
  assign bus.sample_q_out = sample_q_r;
`else
  // QOFF only feeds the quadrature phase.
  logic unused_qoff;
  assign unused_qoff = ^QOFF;
`endif

endmodule
